// File: rtl/nmcu_out_responder.sv
// NMCU output-window bus responder: captures window writes into a stream
// FIFO, keeps shadow words for read-back and answers on the shared bus.
module nmcu_out_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h0200,
  parameter int WIN_BITS = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          sel,
  input  logic                          w_en,
  input  logic [ADDR_WIDTH-1:0]         address_bus,
  inout  wire  [DATA_WIDTH-1:0]         data_bus,
  output logic                          ready,
  output logic                          m_valid,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic [WIN_BITS-1:0]           m_offset,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int NWORDS = 1 << WIN_BITS;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam int CNTW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int EW     = WIN_BITS + DATA_WIDTH;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(LATENCY - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    STALL = 3'd2,
    RESP  = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CNTW-1:0]       cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [WIN_BITS-1:0]   off_q, off_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d;

  logic [DATA_WIDTH-1:0] shadow_q [NWORDS];
  logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;

  logic hit;
  logic full;
  logic push;
  logic pop;
  logic drive_rd;

  assign hit = sel &&
    (address_bus[ADDR_WIDTH-1:WIN_BITS] ==
     BASE_ADDR[ADDR_WIDTH-1:WIN_BITS]);

  assign full     = (count_q == FULL_CNT);
  assign m_valid  = (count_q != '0);
  assign pop      = m_valid && m_ready;
  assign m_data   = fifo_mem[rd_ptr_q][DATA_WIDTH-1:0];
  assign m_offset = fifo_mem[rd_ptr_q][DATA_WIDTH +: WIN_BITS];
  assign fifo_count = count_q;

  assign drive_rd = (state_q == RESP) && !we_q;
  assign data_bus = drive_rd ? shadow_q[off_q] : 'z;

  // State and latched transaction registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      off_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      off_q   <= off_d;
      wdat_q  <= wdat_d;
    end
  end

  // Next state, latency countdown and response strobes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    off_d   = off_q;
    wdat_d  = wdat_q;
    ready   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          we_d   = w_en;
          off_d  = address_bus[WIN_BITS-1:0];
          wdat_d = data_bus;
          cnt_d  = CNT_INIT;
          if (CNT_INIT != '0)
            state_d = WAIT;
          else if (w_en && full)
            state_d = STALL;
          else
            state_d = RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1))
          state_d = (we_q && full) ? STALL : RESP;
      end
      STALL: begin
        if (!full || pop)
          state_d = RESP;
      end
      RESP: begin
        ready   = 1'b1;
        push    = we_q;
        state_d = sel ? HOLD : IDLE;
      end
      HOLD: begin
        if (!sel)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shadow words track the last value written at each offset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NWORDS; i++)
        shadow_q[i] <= '0;
    end else if (push) begin
      shadow_q[off_q] <= wdat_q;
    end
  end

  // FIFO storage; contents are don't-care until pointed at
  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_q] <= {off_q, wdat_q};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop)
        count_q <= count_q + CW'(1);
      else if (pop && !push)
        count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: doc/nmcu_out_responder.md
Name: nmcu_out_responder

Overview:
- Bus responder for an address window on the shared NMCU memory bus (sel / w_en / address_bus / data_bus / ready).
- Captures every NMCU output write into the window into a FIFO and streams the words to a downstream consumer (host DMA or next stage).
- Keeps a shadow copy of each window word so NMCU read-backs return the last written value.
- Sits on the same bus as the main memory; decodes only its own window.

Parameters:
ADDR_WIDTH, 16, bus address width
DATA_WIDTH, 32, bus data width
BASE_ADDR, 16'h0200, window base; must be aligned to 2**WIN_BITS
WIN_BITS, 4, window size is 2**WIN_BITS words
FIFO_DEPTH, 8, stream FIFO entries (power of two, >=2)
LATENCY, 2, cycles from first sampled sel to ready (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low (rst==0 resets on the clock edge)
sel  in  1  bus transaction request, held by the initiator until ready is seen
w_en  in  1  1=write, 0=read; valid while sel is high
address_bus  in  ADDR_WIDTH  word address
data_bus  inout  DATA_WIDTH  write data from initiator; read data driven here only in RESP
ready  out  1  one-cycle completion pulse; 0 whenever not in RESP
m_valid  out  1  stream word available
m_data  out  DATA_WIDTH  stream word
m_offset  out  WIN_BITS  window offset the word was written to
m_ready  in  1  consumer accepts; pop when m_valid&&m_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- hit = sel && address_bus[ADDR_WIDTH-1:WIN_BITS]==BASE_ADDR[ADDR_WIDTH-1:WIN_BITS]; non-hit transactions are ignored entirely (ready=0, data_bus Z).
- Reset (rst==0 at edge): state IDLE, ready=0, data_bus Z, FIFO empty, m_valid=0, fifo_count=0, all shadow words 0. This also applies mid-transaction: the in-flight transaction is abandoned with no ready pulse.
- FSM states: IDLE, WAIT, STALL, RESP, HOLD.
- IDLE: on hit, latch w_en, offset, data_bus (write data) and load cnt=LATENCY-1. Go to RESP if cnt==0, else WAIT.
- WAIT: decrement cnt each cycle. At 0: a write with FIFO full goes to STALL; otherwise go to RESP.
- STALL: remain while full. Leave (to RESP) in a cycle where count<FIFO_DEPTH or a pop occurs in that cycle.
- RESP (exactly 1 cycle): ready=1.
  - Write: push {offset,data} to FIFO and update shadow[offset].
  - Read: drive data_bus=shadow[offset].
  - Next state: HOLD if sel is still high, else IDLE.
- HOLD: wait for sel==0, then IDLE. Prevents one long sel from being taken as two transactions.
- Latency, non-stalled: sel first sampled high at edge N gives ready high in the cycle after edge N+LATENCY-1 (LATENCY cycles). Back-to-back rate is at most one transaction per LATENCY+1 cycles.
- The initiator must keep address, w_en and data stable while sel is high. The responder uses only the values latched in IDLE.
- FIFO:
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop on empty: impossible, since m_valid=0.
  - Push on full: impossible, handled by STALL.
  - m_data/m_offset show the head entry and are held stable while m_valid && !m_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- Read hit during a non-empty FIFO returns the shadow value, which may already be newer than FIFO contents. The FIFO is unaffected by reads.
- Widths: offset = address_bus[WIN_BITS-1:0]. Data is passed through unmodified; no sign handling.

Test Plan:
1. Reset then idle: rst=0 for 2 cycles -> ready=0, m_valid=0, fifo_count=0, data_bus high-Z; read 0x0203 after reset -> returns 0.
2. Single write: sel, w_en=1, addr 0x0201, data 32'hFFFFFFE3 (-29) at edge N -> ready pulses exactly one cycle after edge N+1; m_valid=1, m_data=-29, m_offset=1, fifo_count=1.
3. Out-of-window: write to 0x0100 and 0x0210 -> ready never asserted by this block, FIFO and shadows unchanged.
4. Backpressure: m_ready=0; 9 writes of values 1..9 to 0x0200..0x0208 -> first 8 complete and fifo_count=8. The 9th holds in STALL with no ready. Raise m_ready one cycle -> pop 1, 9th completes. Drain order is 2..9.
5. Read-back: write 29 to 0x0203, then read 0x0203 -> data_bus=29 during the ready cycle and Z otherwise. With sel held 3 extra cycles after ready -> no second ready.
6. Reset mid-op: assert rst=0 in WAIT of a write to 0x0202 -> no ready, no FIFO push, shadow[2]=0. Next transaction behaves as in scenario 2.
